vreg_op_sequencer: RTL and testbench
====================================

Name: vreg_op_sequencer

Overview:
- Two-requester command sequencer and arbiter for the shared versatile register (4-bit load/increment/shift-right/LFSR datapath, mode select C[1:0]).
- Accepts operation commands from requesters A and B and grants them round-robin.
- For each granted command: seeds the register with a parallel load, runs the chosen mode for a programmed number of clocks, then returns the final Q and a count of carry events.
- Sits between the requesters and the versatile register; it is the only driver of the register's C, parallel inputs and serial input.

Parameters:
- WIDTH, 4, register width; must match the versatile register.
- CNT_W, 4, width of the per-command run-cycle count.
- CARRY_W, 4, width of the saturating carry-event counter.

Ports:
- clk  in  1  clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  requester A command accepted (one-cycle pulse).
- a_op  in  2  requester A mode: 00 load, 01 increment, 10 shift right, 11 LFSR.
- a_data  in  WIDTH  requester A seed value.
- a_count  in  CNT_W  requester A run cycles.
- a_sin  in  1  requester A serial-in bit for shifts.
- b_valid, b_ready, b_op, b_data, b_count, b_sin: same as the A ports, for requester B.
- reg_c  out  2  register mode select (C).
- reg_par  out  WIDTH  register parallel inputs.
- reg_serialin  out  1  register serial input.
- reg_q  in  WIDTH  register Q outputs.
- reg_carry  in  1  register carry output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  granted requester (0=A, 1=B).
- rsp_q  out  WIDTH  final register value.
- rsp_carry  out  CARRY_W  carry events seen during RUN (saturating).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Register hold rule:
  - The register has no hold mode.
  - In IDLE and RESP: reg_c=00, reg_par=reg_q, so the register reloads its own value every cycle.
- Reset (asserted low, async):
  - State=IDLE; round-robin pointer favours A; latched command cleared.
  - Outputs: a_ready=b_ready=0, rsp_valid=0, rsp_id=0, rsp_carry=0, busy=0, reg_serialin=0, reg_c=00.
- Reset mid-operation: the command is abandoned immediately, with no response. A requester whose command was in flight must resubmit.
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Grant when any valid is high. If only one is valid, grant it. If both are valid, grant the one not granted last.
  - Pulse the grantee's ready for that cycle only. Latch op, data, count, sin and id. Clear the carry counter. Go to LOAD.
  - Requesters must hold valid and payload until ready; payload is sampled in the ready cycle.
- LOAD (1 cycle):
  - reg_c=00, reg_par=latched data.
  - Next state is RUN if op≠00 and count≠0; otherwise RESP.
- RUN (exactly count cycles):
  - reg_c=latched op, reg_par=latched data, reg_serialin=latched sin.
  - Down-counter loaded with count in LOAD; leave RUN when it reaches 1 at the clock edge.
  - reg_carry is sampled at each RUN-cycle rising edge. If high, rsp_carry increments, saturating at 2^CARRY_W−1.
- RESP:
  - rsp_valid=1; rsp_q=reg_q (stable because of the hold rule); rsp_id and rsp_carry are stable.
  - Stay until rsp_ready=1, then go to IDLE. The pointer updates on completion.
  - No new grant occurs in the RESP→IDLE cycle.
- Latency, grant edge to rsp_valid: 2 cycles for op=00 or count=0; otherwise 2+count cycles.
- op=00 with a nonzero count: count is ignored (LOAD then RESP).
- Requests arriving while busy stay pending with ready low; a requester is never starved. With both requesters continuously valid, grants strictly alternate.

Test Plan:
- A: op=00, data=4'hA, count=5, no contention -> a_ready pulse; rsp_valid 2 cycles later; rsp_q=4'hA, rsp_id=0, rsp_carry=0; register holds 4'hA afterwards.
- A: op=01, data=4'hE, count=3 -> RUN lasts 3 cycles; rsp_q=4'h1, rsp_carry=1 (single wrap F→0).
- B: op=10, data=4'b0000, sin=1, count=2 -> rsp_q=4'b1100, rsp_id=1; during RUN reg_serialin=1 and reg_c=10.
- A and B both valid with identical increment commands -> A served first, then B. Keep both valid for 4 commands -> rsp_id sequence 0,1,0,1. No ready pulse while busy.
- rsp_ready held low 6 cycles in RESP -> rsp_valid stays high with rsp_q constant; register value unchanged (reg_c=00, reg_par=reg_q).
- reset pulsed low in the 2nd RUN cycle of a count=8 command -> immediate IDLE; busy=0, rsp_valid=0; no response. The next A command completes normally.

Source files
------------

// File: rtl/vreg_op_sequencer.sv
// Round-robin command sequencer for the shared versatile register: seeds it with a load,
// runs the granted mode for a programmed number of clocks, then returns Q and a carry count.
module vreg_op_sequencer #(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 4,
    parameter int CARRY_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [1:0]         a_op,
    input  logic [WIDTH-1:0]   a_data,
    input  logic [CNT_W-1:0]   a_count,
    input  logic               a_sin,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic [1:0]         b_op,
    input  logic [WIDTH-1:0]   b_data,
    input  logic [CNT_W-1:0]   b_count,
    input  logic               b_sin,
    output logic [1:0]         reg_c,
    output logic [WIDTH-1:0]   reg_par,
    output logic               reg_serialin,
    input  logic [WIDTH-1:0]   reg_q,
    input  logic               reg_carry,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_q,
    output logic [CARRY_W-1:0] rsp_carry,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t             state, state_nxt;
    logic               last_id;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sin_q;
    logic               id_q;
    logic [CARRY_W-1:0] carry_q;
    logic               grant;
    logic               grant_b;

    // Grant is gated by reset so no ready pulse escapes while reset is held low.
    // last_id resets to B so that A wins the first contended grant.
    always_comb begin
        grant   = reset && (state == IDLE) && (a_valid || b_valid);
        grant_b = b_valid && (!a_valid || !last_id);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = LOAD;
            LOAD: state_nxt = ((op_q != 2'b00) && (cnt_q != '0)) ? RUN : RESP;
            RUN:  if (cnt_q == CNT_W'(1)) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last_id <= 1'b1;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            sin_q   <= 1'b0;
            id_q    <= 1'b0;
            carry_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_q    <= grant_b ? b_op    : a_op;
                        data_q  <= grant_b ? b_data  : a_data;
                        cnt_q   <= grant_b ? b_count : a_count;
                        sin_q   <= grant_b ? b_sin   : a_sin;
                        id_q    <= grant_b;
                        carry_q <= '0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (reg_carry && (carry_q != '1))
                        carry_q <= carry_q + CARRY_W'(1);
                end
                RESP: if (rsp_ready) last_id <= id_q;
                default: ;
            endcase
        end
    end

    // With no hold mode, idle and response states keep Q by reloading it through the load path.
    always_comb begin
        a_ready      = grant && !grant_b;
        b_ready      = grant && grant_b;
        busy         = (state != IDLE);
        rsp_valid    = (state == RESP);
        rsp_id       = id_q;
        rsp_q        = reg_q;
        rsp_carry    = carry_q;
        reg_c        = 2'b00;
        reg_par      = reg_q;
        reg_serialin = 1'b0;
        case (state)
            LOAD: reg_par = data_q;
            RUN: begin
                reg_c        = op_q;
                reg_par      = data_q;
                reg_serialin = sin_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vreg_op_sequencer.sv
// Directed bench for vreg_op_sequencer with a behavioural versatile register attached.
module tb_vreg_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, a_sin, b_valid, b_sin;
    logic       a_ready, b_ready;
    logic [1:0] a_op, b_op;
    logic [3:0] a_data, b_data, a_count, b_count;
    logic [1:0] reg_c;
    logic [3:0] reg_par;
    logic       reg_serialin;
    logic [3:0] vq = 4'h0;
    logic       vcarry;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0] rsp_q, rsp_carry;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Versatile register: load / increment / shift right (serial into MSB) / LFSR.
    always @(posedge clk) begin
        case (reg_c)
            2'b00: vq <= reg_par;
            2'b01: vq <= vq + 4'h1;
            2'b10: vq <= {reg_serialin, vq[3:1]};
            default: vq <= {vq[1] ^ vq[0], vq[3:1]};
        endcase
    end
    assign vcarry = (reg_c == 2'b01) && (vq == 4'hF);

    vreg_op_sequencer #(.WIDTH(4), .CNT_W(4), .CARRY_W(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_data(a_data),
        .a_count(a_count), .a_sin(a_sin),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_data(b_data),
        .b_count(b_count), .b_sin(b_sin),
        .reg_c(reg_c), .reg_par(reg_par), .reg_serialin(reg_serialin),
        .reg_q(vq), .reg_carry(vcarry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_carry(rsp_carry), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    end

    initial begin
        reset = 1'b0; rsp_ready = 1'b0;
        a_valid = 1'b1; a_op = 2'b00; a_data = 4'h0; a_count = 4'h0; a_sin = 1'b0;
        b_valid = 1'b0; b_op = 2'b00; b_data = 4'h0; b_count = 4'h0; b_sin = 1'b0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_reg_c", reg_c, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_serialin", reg_serialin, 0);
        a_valid = 1'b0;
        reset = 1'b1;
        tick;

        // A: load 0xA, count ignored
        a_valid = 1'b1; a_op = 2'b00; a_data = 4'hA; a_count = 4'd5; #1;
        chk("t1_a_ready", a_ready, 1);
        chk("t1_b_ready", b_ready, 0);
        tick; a_valid = 1'b0; #1;
        chk("t1_load_busy", busy, 1);
        chk("t1_load_ready", a_ready, 0);
        chk("t1_load_par", reg_par, 4'hA);
        tick;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_q", rsp_q, 4'hA);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_carry", rsp_carry, 0);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0; #1;
        chk("t1_idle_busy", busy, 0);
        tick;
        chk("t1_reg_hold", vq, 4'hA);

        // A: increment from 0xE for 3 cycles, one wrap
        a_valid = 1'b1; a_op = 2'b01; a_data = 4'hE; a_count = 4'd3; #1;
        chk("t2_a_ready", a_ready, 1);
        tick; a_valid = 1'b0; tick;
        chk("t2_run_c", reg_c, 2'b01);
        tick; tick;
        chk("t2_run3_no_rsp", rsp_valid, 0);
        tick;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_q", rsp_q, 4'h1);
        chk("t2_rsp_carry", rsp_carry, 1);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0; #1;

        // B: shift right with sin=1 for 2 cycles
        b_valid = 1'b1; b_op = 2'b10; b_data = 4'h0; b_count = 4'd2; b_sin = 1'b1; #1;
        chk("t3_b_ready", b_ready, 1);
        chk("t3_a_ready", a_ready, 0);
        tick; b_valid = 1'b0; tick;
        chk("t3_run_sin", reg_serialin, 1);
        chk("t3_run_c", reg_c, 2'b10);
        tick; tick;
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_q", rsp_q, 4'b1100);
        chk("t3_rsp_id", rsp_id, 1);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0; #1;

        // Both valid: strict alternation starting with A; first response held 6 cycles
        a_valid = 1'b1; a_op = 2'b01; a_data = 4'h3; a_count = 4'd2; a_sin = 1'b0;
        b_valid = 1'b1; b_op = 2'b01; b_data = 4'h3; b_count = 4'd2; b_sin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_a_ready", a_ready, (k % 2) == 0);
            chk("t4_b_ready", b_ready, (k % 2) == 1);
            tick;
            chk("t4_load_no_ready", {a_ready, b_ready}, 2'b00);
            tick;
            chk("t4_run_no_ready", {a_ready, b_ready}, 2'b00);
            tick; tick;
            chk("t4_rsp_valid", rsp_valid, 1);
            chk("t4_rsp_id", rsp_id, k % 2);
            chk("t4_rsp_q", rsp_q, 4'h5);
            chk("t4_rsp_carry", rsp_carry, 0);
            chk("t4_resp_no_ready", {a_ready, b_ready}, 2'b00);
            if (k == 0) begin
                for (int h = 0; h < 6; h++) begin
                    tick;
                    chk("t5_hold_valid", rsp_valid, 1);
                    chk("t5_hold_q", rsp_q, 4'h5);
                    chk("t5_hold_reg", vq, 4'h5);
                    chk("t5_hold_c", reg_c, 2'b00);
                    chk("t5_hold_par", reg_par, 4'h5);
                end
            end
            rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        end
        a_valid = 1'b0; b_valid = 1'b0; #1;

        // Reset in 2nd RUN cycle of a count=8 command
        a_valid = 1'b1; a_op = 2'b01; a_data = 4'h0; a_count = 4'd8; #1;
        chk("t6_a_ready", a_ready, 1);
        tick; a_valid = 1'b0; tick; tick;
        chk("t6_run_busy", busy, 1);
        reset = 1'b0; #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_c", reg_c, 2'b00);
        tick; tick;
        chk("t6_rst_no_rsp", rsp_valid, 0);
        reset = 1'b1; tick;
        chk("t6_idle_after", busy, 0);
        a_valid = 1'b1; a_op = 2'b00; a_data = 4'h6; a_count = 4'd0; #1;
        chk("t6_next_ready", a_ready, 1);
        tick; a_valid = 1'b0; tick;
        chk("t6_next_rsp_valid", rsp_valid, 1);
        chk("t6_next_rsp_q", rsp_q, 4'h6);
        chk("t6_next_rsp_id", rsp_id, 0);
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0; #1;
        chk("t6_next_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
